// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - default widths / memory size used as parameter defaults by dm_arbiter
//   - access FSM state encoding (IDLE, ISSUE, CAPT)
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DM_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        CAPT  = 2'b10
    } state_e;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-request round-robin picker with a last-winner register.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit N = requester N)
//   upd_en     : commit the current pick as "last served" at the next edge
//   any        : at least one request present
//   sel        : index of the winning requester (valid when any = 1)
// After reset the register reads "port 1 served last", so port 0 wins a tie.
// -----------------------------------------------------------------------------
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic       any,
    output logic       sel
);

    logic last_q;
    logic last_d;

    always_comb begin
        any = |req;
        // On a tie the port that was not served last wins; otherwise the
        // single requester wins (req[1] alone -> 1, req[0] alone or none -> 0).
        if (req == 2'b11) begin
            sel = ~last_q;
        end else begin
            sel = req[1];
        end
        last_d = (upd_en && any) ? sel : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Arbitrates two requesters (m0, m1) onto a single data-memory port.
// Each access takes three cycles after the request is sampled in IDLE:
//   cycle 1 (ISSUE): mN_gnt pulse, memory strobe
//   cycle 2 (CAPT) : memory read data valid, captured at the end of the cycle
//   cycle 3 (IDLE) : mN_done pulse (mN_err alongside), next request sampled
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mN_req/we/addr/wdata  (in)       request, store flag, byte address, data
//   mN_gnt/done/err       (out)      one-cycle pulses to requester N
//   mN_rdata              (out)      last load result for requester N
//   dm_mem_write/read     (out)      memory strobes
//   dm_address/data_write (out)      memory address and store data
//   dm_data_read          (in)       memory load data (cycle after strobe)
// Optional feature: define DM_ARB_CHECK_EN to reject misaligned or
// out-of-range accesses (no strobe, done with err).
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DM_DEPTH = DEF_DM_DEPTH
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              dm_mem_write,
    output logic              dm_mem_read,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_data_write,
    input  logic [DATA_W-1:0] dm_data_read
);

`ifdef DM_ARB_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DM_DEPTH - 4);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              arb_any;
    logic              arb_sel;
    logic              arb_upd;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_bad;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({m1_req, m0_req}),
        .upd_en (arb_upd),
        .any    (arb_any),
        .sel    (arb_sel)
    );

    assign win_we    = arb_sel ? m1_we    : m0_we;
    assign win_addr  = arb_sel ? m1_addr  : m0_addr;
    assign win_wdata = arb_sel ? m1_wdata : m0_wdata;
    // Folds to 0 when the check is compiled out; the address is never altered.
    assign win_bad   = CHK_EN && ((win_addr[1:0] != 2'b00) || (win_addr > MAX_ADDR));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        bad_d    = bad_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        err_d    = 2'b00;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        arb_upd  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    // Latch the winner so requesters may change inputs after gnt;
                    // gnt/strobes are registered here so they appear in ISSUE.
                    state_d        = ISSUE;
                    arb_upd        = 1'b1;
                    sel_d          = arb_sel;
                    we_d           = win_we;
                    addr_d         = win_addr;
                    wdata_d        = win_wdata;
                    bad_d          = win_bad;
                    gnt_d[arb_sel] = 1'b1;
                    wr_d           = win_we  && !win_bad;
                    rd_d           = !win_we && !win_bad;
                end
            end
            ISSUE: begin
                state_d = CAPT;
            end
            CAPT: begin
                // Read data is valid this cycle; done/err land in the next IDLE.
                state_d       = IDLE;
                done_d[sel_q] = 1'b1;
                err_d[sel_q]  = bad_q;
                if (!we_q && !bad_q) begin
                    if (sel_q) begin
                        rdata1_d = dm_data_read;
                    end else begin
                        rdata0_d = dm_data_read;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            bad_q    <= bad_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt        = gnt_q[0];
    assign m1_gnt        = gnt_q[1];
    assign m0_done       = done_q[0];
    assign m1_done       = done_q[1];
    assign m0_err        = err_q[0];
    assign m1_err        = err_q[1];
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign dm_mem_write  = wr_q;
    assign dm_mem_read   = rd_q;
    assign dm_address    = addr_q;
    assign dm_data_write = wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Scoreboard bench for dm_arbiter. A transaction-level model predicts, at each
// request sampling point, which port is served and what gnt/strobe/done/err/
// rdata it must see; a separate monitor compares DUT outputs against the
// queued expectations. A behavioural memory answers the DUT's strobes.
// Honours DM_ARB_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_mem_write, dm_mem_read;
    logic [31:0] dm_address, dm_data_write, dm_data_read;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        int          port;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        int          cyc;
        int          port;
        logic        err;
        logic        upd;
        logic [31:0] rdata;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    dm_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_gnt        (m0_gnt),
        .m0_done       (m0_done),
        .m0_rdata      (m0_rdata),
        .m0_err        (m0_err),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_gnt        (m1_gnt),
        .m1_done       (m1_done),
        .m1_rdata      (m1_rdata),
        .m1_err        (m1_err),
        .dm_mem_write  (dm_mem_write),
        .dm_mem_read   (dm_mem_read),
        .dm_address    (dm_address),
        .dm_data_write (dm_data_write),
        .dm_data_read  (dm_data_read)
    );

    initial forever #5 clk = ~clk;

    // Initial memory contents; word 4 (byte 0x10) holds 0x000000AB.
    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_00AB;
        return {8'(i), 8'hC3, 8'(~i), 8'h5A};
    endfunction

    // Behavioural data memory: word index is addr[9:2], read data next cycle.
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (dm_mem_write) mem[dm_address[9:2]] <= dm_data_write;
            if (dm_mem_read)  dm_data_read <= mem[dm_address[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic addr_rejected(input logic [31:0] a);
`ifdef DM_ARB_CHECK_EN
        return (a % 4 != 0) || (a > 32'(1024 - 4));
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level reference model: one access per 3 cycles, round-robin.
    initial begin
        logic [31:0] refmem [256];
        int          next_free;
        int          last;
        int          w;
        logic        we, bad;
        logic [31:0] a, d;
        logic        pend;
        int          pend_cyc;
        logic [7:0]  pend_idx;
        logic [31:0] pend_dat;
        for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
        next_free = 0;
        last      = 1;
        pend      = 1'b0;
        pend_cyc  = 0;
        pend_idx  = 8'd0;
        pend_dat  = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                next_free = 0;
                last      = 1;
                pend      = 1'b0;
            end else begin
                // A store takes effect once its strobe edge has passed.
                if (pend && cyc == pend_cyc) begin
                    refmem[pend_idx] = pend_dat;
                    pend = 1'b0;
                end
                if (cyc >= next_free && (m0_req || m1_req)) begin
                    if (m0_req && m1_req) w = 1 - last;
                    else                  w = m1_req ? 1 : 0;
                    last = w;
                    we   = w ? m1_we    : m0_we;
                    a    = w ? m1_addr  : m0_addr;
                    d    = w ? m1_wdata : m0_wdata;
                    bad  = addr_rejected(a);
                    gq.push_back('{cyc, w, we && !bad, !we && !bad, a, d});
                    dq.push_back('{cyc + 2, w, bad, !we && !bad, refmem[a[9:2]]});
                    if (we && !bad) begin
                        pend     = 1'b1;
                        pend_cyc = cyc + 1;
                        pend_idx = a[9:2];
                        pend_dat = d;
                    end
                    next_free = cyc + 3;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle.
    initial begin
        logic [31:0] exp_rd0, exp_rd1;
        gexp_t g;
        dexp_t e;
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gq.delete();
                dq.delete();
                exp_rd0 = 32'd0;
                exp_rd1 = 32'd0;
                chk("reset_outputs",
                    {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, dm_mem_write, dm_mem_read,
                     (dm_address != 0), (dm_data_write != 0), (m0_rdata != 0), (m1_rdata != 0)}, 64'd0);
            end else begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    g = gq.pop_front();
                    chk("missing_gnt", 64'd0, 64'(g.port + 1));
                end
                while (dq.size() > 0 && dq[0].cyc < cyc) begin
                    e = dq.pop_front();
                    chk("missing_done", 64'd0, 64'(e.port + 1));
                end
                if (m0_gnt || m1_gnt) begin
                    if (gq.size() == 0 || gq[0].cyc != cyc) begin
                        chk("unexpected_gnt", {m1_gnt, m0_gnt}, 64'd0);
                    end else begin
                        g = gq.pop_front();
                        chk("gnt_port", {m1_gnt, m0_gnt}, (g.port == 1) ? 2'b10 : 2'b01);
                        chk("strobe_wr", dm_mem_write, g.wr);
                        chk("strobe_rd", dm_mem_read, g.rd);
                        chk("dm_address", dm_address, g.addr);
                        if (g.wr) chk("dm_data_write", dm_data_write, g.wd);
                    end
                end else begin
                    chk("strobes_idle", {dm_mem_write, dm_mem_read}, 64'd0);
                end
                if (m0_done || m1_done) begin
                    if (dq.size() == 0 || dq[0].cyc != cyc) begin
                        chk("unexpected_done", {m1_done, m0_done}, 64'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("done_port", {m1_done, m0_done}, (e.port == 1) ? 2'b10 : 2'b01);
                        chk("err", {m1_err, m0_err},
                            e.err ? ((e.port == 1) ? 2'b10 : 2'b01) : 2'b00);
                        if (e.upd) begin
                            if (e.port == 1) exp_rd1 = e.rdata;
                            else             exp_rd0 = e.rdata;
                        end
                    end
                end else begin
                    chk("err_without_done", {m1_err, m0_err}, 64'd0);
                end
                chk("m0_rdata", m0_rdata, exp_rd0);
                chk("m1_rdata", m1_rdata, exp_rd1);
            end
        end
    end

    task automatic access(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
        bit got;
        if (port == 1) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = (port == 1) ? m1_gnt : m0_gnt;
        end
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        // Leaves the caller in the done cycle of this access.
        repeat (2) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if (r == 8) return {22'd0, 10'($urandom_range(0, 1023))};
        return 32'($urandom_range(1024, 4096));
    endfunction

    initial begin
        int order[$];
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // m0 load from 0x10
        access(0, 1'b0, 32'h10, 32'h0);
        chk("m0_done_load10", m0_done, 1'b1);
        chk("m0_rdata_load10", m0_rdata, 32'h0000_00AB);

        // m1 store then load back
        access(1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        access(1, 1'b0, 32'h20, 32'h0);
        chk("m1_rdata_after_store", m1_rdata, 32'hDEAD_BEEF);

        // Both ports requesting from reset: m0,m1,m0,m1 every 3 cycles
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (m0_gnt) order.push_back(0);
            if (m1_gnt) order.push_back(1);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("rr_grant_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_grant_order", order[i], i % 2);
        repeat (2) @(posedge clk); #1;

        // Reset during CAPT of an m0 load aborts it; next tie goes to m0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        for (int i = 0; i < 20 && !m0_gnt; i++) begin @(posedge clk); #1; end
        chk("abort_gnt_seen", m0_gnt, 1'b1);
        m0_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h48; m1_we = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_no_done", m0_done, 1'b0);
        chk("abort_rdata_cleared", m0_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tie_after_reset", {m1_gnt, m0_gnt}, 2'b01);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Misaligned and out-of-range loads from m1
        access(1, 1'b0, 32'h2, 32'h0);
`ifdef DM_ARB_CHECK_EN
        chk("misaligned_err", {m1_done, m1_err}, 2'b11);
`else
        chk("misaligned_no_err", {m1_done, m1_err}, 2'b10);
`endif
        @(posedge clk); #1;
        access(1, 1'b0, 32'h400, 32'h0);
`ifdef DM_ARB_CHECK_EN
        chk("out_of_range_err", {m1_done, m1_err}, 2'b11);
`else
        chk("out_of_range_no_err", {m1_done, m1_err}, 2'b10);
`endif
        @(posedge clk); #1;

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (i == 300) rst_n = 1'b0;
            if (i == 302) rst_n = 1'b1;
            m0_req   = ($urandom_range(0, 9) < 6);
            m1_req   = ($urandom_range(0, 9) < 6);
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_addr  = rand_addr();
            m1_addr  = rand_addr();
            m0_wdata = $urandom;
            m1_wdata = $urandom;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("gnt_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
